traffic_phase_ctrl: RTL

Two-way intersection sequencer built around a 1-second tick prescaler. The block sequences the tick generator, counts ticks per phase and drives NS/EW lamp outputs through green, yellow and all-red. An optional pedestrian walk phase is served at all-red boundaries. It sits above the counter/overflow primitives in the traffic state machine design and is the only consumer of the prescaler's overflow pulse.

---
 rtl/traffic_pkg.sv | 46 ++++
 rtl/tick_prescaler.sv | 41 ++++
 rtl/traffic_phase_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase controller.
//   phase_e  : phase state codes (codes 6-7 are illegal; code 5 is illegal
//              unless TRAFFIC_PED_EN is defined)
//   dir_e    : which road gets the next green
//   LAMP_*   : one-hot {red,yellow,green} lamp encodings
//   lamps_of : lamp decode for a phase, returned as {ns, ew}
//   dur_sat  : duration with 0 treated as 1
package traffic_pkg;

  typedef enum logic [2:0] {
    StAllRed   = 3'd0,
    StNsGreen  = 3'd1,
    StNsYellow = 3'd2,
    StEwGreen  = 3'd3,
    StEwYellow = 3'd4,
    StPedWalk  = 3'd5
  } phase_e;

  typedef enum logic {
    DirNs = 1'b0,
    DirEw = 1'b1
  } dir_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  function automatic int unsigned dur_sat(int unsigned d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [5:0] lamps_of(phase_e s);
    case (s)
      StNsGreen:  return {LAMP_GRN, LAMP_RED};
      StNsYellow: return {LAMP_YEL, LAMP_RED};
      StEwGreen:  return {LAMP_RED, LAMP_GRN};
      StEwYellow: return {LAMP_RED, LAMP_YEL};
      default:    return {LAMP_RED, LAMP_RED};
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running tick prescaler.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   en_i    : count enable; low freezes the counter and suppresses tick_o
//   clr_i   : synchronous clear, has priority over counting
//   tick_o  : one-cycle pulse on the last count before wrapping (TICK_MAX-1)
module tick_prescaler #(
  parameter int unsigned TICK_MAX = 40000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_MAX - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  assign tick_o = en_i & (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-way intersection phase sequencer.
// Sequence: ALL_RED -> NS green/yellow -> ALL_RED -> EW green/yellow -> ...
// with an optional pedestrian walk phase taken from ALL_RED when a request
// is pending. Walk support is built only when TRAFFIC_PED_EN is defined.
//   clk_i, rst_ni   : clock and asynchronous active-low reset
//   enable_i        : low freezes prescaler, tick counter and state
//   ped_req_i       : pedestrian request (level or pulse)
//   ns_lamp_o       : {red,yellow,green} north-south
//   ew_lamp_o       : {red,yellow,green} east-west
//   walk_o          : pedestrian walk lamp
//   ped_pending_o   : request latched and not yet served
//   phase_o         : current state code
//   tick_o          : prescaler overflow pulse
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_MAX = 40000000,
  parameter int unsigned GREEN_T  = 20,
  parameter int unsigned YELLOW_T = 3,
  parameter int unsigned ALLRED_T = 2,
  parameter int unsigned PED_T    = 10
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic       ped_req_i,
  output logic [2:0] ns_lamp_o,
  output logic [2:0] ew_lamp_o,
  output logic       walk_o,
  output logic       ped_pending_o,
  output logic [2:0] phase_o,
  output logic       tick_o
);

  localparam int unsigned GreenD  = dur_sat(GREEN_T);
  localparam int unsigned YellowD = dur_sat(YELLOW_T);
  localparam int unsigned AllRedD = dur_sat(ALLRED_T);
  localparam int unsigned PedD    = dur_sat(PED_T);
  localparam int unsigned MaxD    = max_u(max_u(GreenD, YellowD), max_u(AllRedD, PedD));
  localparam int unsigned CntW    = $clog2(MaxD + 1);

  phase_e          state_d, state_q;
  dir_e            next_dir_d, next_dir_q;
  logic [CntW-1:0] elapsed_d, elapsed_q;
  logic [CntW-1:0] dur_m1;
  logic [2:0]      ns_lamp_d, ns_lamp_q, ew_lamp_d, ew_lamp_q;
  logic            tick;
  logic            adv;
  logic            phase_chg;

  tick_prescaler #(
    .TICK_MAX(TICK_MAX)
  ) u_prescaler (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (enable_i),
    .clr_i (phase_chg),
    .tick_o(tick)
  );

  // Elapsed-tick limit for the current phase.
  always_comb begin
    dur_m1 = CntW'(AllRedD - 1);
    case (state_q)
      StNsGreen, StEwGreen:   dur_m1 = CntW'(GreenD - 1);
      StNsYellow, StEwYellow: dur_m1 = CntW'(YellowD - 1);
      StPedWalk:              dur_m1 = CntW'(PedD - 1);
      default:                dur_m1 = CntW'(AllRedD - 1);
    endcase
  end

  assign adv       = tick & (elapsed_q == dur_m1);
  assign phase_chg = (state_d != state_q);

`ifdef TRAFFIC_PED_EN
  logic ped_pending_d, ped_pending_q, walk_q;

  // Requests are ignored while walking and on the edge that enters the walk.
  always_comb begin
    ped_pending_d = ped_pending_q;
    if ((state_d == StPedWalk) && (state_q != StPedWalk)) begin
      ped_pending_d = 1'b0;
    end else if ((state_q != StPedWalk) && ped_req_i) begin
      ped_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ped_pending_q <= 1'b0;
      walk_q        <= 1'b0;
    end else begin
      ped_pending_q <= ped_pending_d;
      walk_q        <= (state_d == StPedWalk);
    end
  end

  assign ped_pending_o = ped_pending_q;
  assign walk_o        = walk_q;
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req_i;
  assign ped_pending_o  = 1'b0;
  assign walk_o         = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    next_dir_d = next_dir_q;
    case (state_q)
      StAllRed: begin
        if (adv) begin
          state_d = (next_dir_q == DirEw) ? StEwGreen : StNsGreen;
`ifdef TRAFFIC_PED_EN
          // Decision uses the latched flag, so a request on this edge waits.
          if (ped_pending_q) state_d = StPedWalk;
`endif
        end
      end
      StNsGreen:  if (adv) state_d = StNsYellow;
      StNsYellow: begin
        if (adv) begin
          state_d    = StAllRed;
          next_dir_d = DirEw;
        end
      end
      StEwGreen:  if (adv) state_d = StEwYellow;
      StEwYellow: begin
        if (adv) begin
          state_d    = StAllRed;
          next_dir_d = DirNs;
        end
      end
`ifdef TRAFFIC_PED_EN
      StPedWalk: begin
        if (adv) state_d = (next_dir_q == DirEw) ? StEwGreen : StNsGreen;
      end
`endif
      // Illegal codes recover at once.
      default: state_d = StAllRed;
    endcase
  end

  always_comb begin
    elapsed_d = elapsed_q;
    if (phase_chg) begin
      elapsed_d = '0;
    end else if (tick) begin
      elapsed_d = elapsed_q + 1'b1;
    end
    {ns_lamp_d, ew_lamp_d} = lamps_of(state_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StAllRed;
      next_dir_q <= DirNs;
      elapsed_q  <= '0;
      ns_lamp_q  <= LAMP_RED;
      ew_lamp_q  <= LAMP_RED;
    end else begin
      state_q    <= state_d;
      next_dir_q <= next_dir_d;
      elapsed_q  <= elapsed_d;
      ns_lamp_q  <= ns_lamp_d;
      ew_lamp_q  <= ew_lamp_d;
    end
  end

  assign ns_lamp_o = ns_lamp_q;
  assign ew_lamp_o = ew_lamp_q;
  assign phase_o   = state_q;
  assign tick_o    = tick;

endmodule
